// File: rtl/sl_cdc_rx_buffer_pkg.sv
// Shared sizing helpers for the valid-flagged CDC path.
// Used by the crossing stage, this buffer and its consumers.
package sl_cdc_rx_buffer_pkg;

  // Pointer width for a DEPTH-entry store (at least 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Bit position of the valid flag in a crossing word.
  function automatic int valid_idx(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/sl_rx_buf_mem.sv
// Register-array storage for the rx buffer.
// Ports: clk, we/waddr/wdata (sync write), raddr -> rdata (async read).
module sl_rx_buf_mem #(
  parameter int DW    = 192,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sl_cdc_rx_buffer.sv
// Elastic FWFT buffer behind the valid-flagged CDC stage.
// Ports: clk, rst (async, high), data_in (MSB=valid),
//   dout/dout_valid/dout_ready (consumer handshake),
//   occupancy, almost_full, overflow, drop_count, clr_stats.
module sl_cdc_rx_buffer
  import sl_cdc_rx_buffer_pkg::*;
#(
  parameter int WIDTH        = 193,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-2:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     drop_count,
  input  logic                     clr_stats
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = occ_w(DEPTH);
  localparam int VI = valid_idx(WIDTH);
  localparam int DW = WIDTH - 1;

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [OW-1:0]        r_occ;
  logic                 r_afull;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_drop;

  logic                 w_wr_req;
  logic                 w_rd;
  logic                 w_full;
  logic                 w_nonempty;
  logic                 w_wr_acc;
  logic                 w_drop;
  logic [OW-1:0]        w_occ_nxt;
  logic [CNT_WIDTH-1:0] w_drop_inc;
  logic [DW-1:0]        w_rdata;

  assign w_wr_req   = data_in[VI];
  assign w_nonempty = (r_occ != '0);
  assign w_full     = (r_occ == OW'(DEPTH));
  assign w_rd       = w_nonempty & dout_ready;
  // A read in the same cycle frees the slot the write lands in.
  assign w_wr_acc   = w_wr_req & (~w_full | w_rd);
  assign w_drop     = w_wr_req & w_full & ~w_rd;

  assign w_drop_inc = (&r_drop) ? r_drop
                                : r_drop + CNT_WIDTH'(1);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr_acc, w_rd})
      2'b10:   w_occ_nxt = r_occ + OW'(1);
      2'b01:   w_occ_nxt = r_occ - OW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd)     r_rd_ptr <= r_rd_ptr + PW'(1);
      r_occ   <= w_occ_nxt;
      r_afull <= (w_occ_nxt >= OW'(AFULL_THRESH));
    end
  end

  // A drop coinciding with a clear counts as the first event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      r_drop <= clr_stats ? CNT_WIDTH'(1) : w_drop_inc;
    end else if (clr_stats) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end
  end

  sl_rx_buf_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata (data_in[DW-1:0]),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign dout_valid  = w_nonempty;
  assign dout        = w_nonempty ? w_rdata : '0;
  assign occupancy   = r_occ;
  assign almost_full = r_afull;
  assign overflow    = r_ovf;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_sl_cdc_rx_buffer.sv
// Self-checking bench for sl_cdc_rx_buffer.
// Queue scoreboard plus table vectors and corner sequences.
module tb_sl_cdc_rx_buffer;

  localparam int W  = 193;
  localparam int PL = 192;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [PL-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [3:0]    occupancy;
  logic          almost_full;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          clr_stats;

  always #5 clk = ~clk;

  sl_cdc_rx_buffer #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_THRESH (6),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .occupancy   (occupancy),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clr_stats   (clr_stats)
  );

  int total = 0;
  int bad   = 0;

  logic [PL-1:0] m_q[$];
  logic          m_ovf;
  logic [CW-1:0] m_cnt;

  typedef struct {
    logic          v;
    logic [PL-1:0] p;
    logic          rdy;
    logic          clr;
    logic          ev;
    logic [PL-1:0] ed;
    int            eo;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm,
                     input logic [PL-1:0] act,
                     input logic [PL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_state();
    logic [PL-1:0] hd;
    hd = (m_q.size() != 0) ? m_q[0] : '0;
    chk("dout_valid", dout_valid, m_q.size() != 0);
    chk("dout", dout, hd);
    chk("occupancy", occupancy, m_q.size());
    chk("almost_full", almost_full, m_q.size() >= 6);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_cnt);
  endtask

  // Called just after a posedge: drive, advance model, step, check.
  task automatic cyc(input logic v, input logic [PL-1:0] p,
                     input logic rdy, input logic clr);
    logic rd;
    logic full;
    data_in    = {v, p};
    dout_ready = rdy;
    clr_stats  = clr;
    rd   = (m_q.size() != 0) && rdy;
    full = (m_q.size() == D);
    if (rd) begin
      chk("sb_pop", dout, m_q[0]);
      void'(m_q.pop_front());
    end
    if (v && (!full || rd)) begin
      m_q.push_back(p);
    end
    if (v && full && !rd) begin
      m_ovf = 1'b1;
      if (clr)              m_cnt = 1;
      else if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    logic [PL-1:0] rp;

    tbl[0] = '{1'b1, 192'hA, 1'b1, 1'b0, 1'b1, 192'hA, 1};
    tbl[1] = '{1'b1, 192'hB, 1'b1, 1'b0, 1'b1, 192'hB, 1};
    tbl[2] = '{1'b1, 192'hC, 1'b1, 1'b0, 1'b1, 192'hC, 1};
    tbl[3] = '{1'b0, 192'h0, 1'b1, 1'b0, 1'b0, 192'h0, 0};

    rst        = 1'b1;
    data_in    = '0;
    dout_ready = 1'b0;
    clr_stats  = 1'b0;
    m_ovf      = 1'b0;
    m_cnt      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;

    // Pass-through, one cycle latency, occupancy peaks at 1.
    for (int i = 0; i < 4; i++) begin
      cyc(tbl[i].v, tbl[i].p, tbl[i].rdy, tbl[i].clr);
      chk("tbl_valid", dout_valid, tbl[i].ev);
      chk("tbl_dout", dout, tbl[i].ed);
      chk("tbl_occ", occupancy, tbl[i].eo);
    end

    // Fill past full with no consumer.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, PL'(32'h100 + i), 1'b0, 1'b0);
      chk("afull_rise", almost_full, i >= 5);
    end
    chk("full_occ", occupancy, 8);
    chk("full_ovf", overflow, 1'b1);
    chk("full_drop", drop_count, 1);
    chk("full_head", dout, 192'h100);

    // Full with a simultaneous read: write accepted.
    cyc(1'b1, 192'h200, 1'b1, 1'b0);
    chk("fr_occ", occupancy, 8);
    chk("fr_drop", drop_count, 1);

    // Clear racing a drop, then clear alone.
    cyc(1'b1, 192'h300, 1'b0, 1'b1);
    chk("clr_race_ovf", overflow, 1'b1);
    chk("clr_race_cnt", drop_count, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_cnt", drop_count, 0);

    // Saturation of the 4-bit drop counter.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, PL'(32'h400 + i), 1'b0, 1'b0);
    end
    chk("sat_cnt", drop_count, 15);

    // Drain to 5 entries, then reset mid-stream.
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst_occ", occupancy, 5);
    data_in    = '0;
    dout_ready = 1'b0;
    rst        = 1'b1;
    #2;
    m_q.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_occ", occupancy, 0);
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 192'h55, 1'b0, 1'b0);
    chk("post_rst_dout", dout, 192'h55);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      rp = {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
      cyc($urandom_range(0, 1) == 1, rp,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
